fir_tap_sequencer: RTL and testbench



---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_tap_sequencer_sample_ring_buffer.sv | 51 +++++
 rtl/fir_tap_sequencer.sv | 119 +++++++++++
 tb/tb_fir_tap_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter stage and its feeders.
//   FIR_TAPS        : number of filter taps (history depth of the sequencer)
//   AUDIO_WIDTH     : default audio sample width in bits
//   fir_seq_state_t : state encoding of the tap sequencer FSM
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_TAPS    = 32;
    localparam int AUDIO_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fir_seq_state_t;

endpackage

// File: rtl/fir_tap_sequencer_sample_ring_buffer.sv
// ---------------------------------------------------------------------------
// sample_ring_buffer
// TAPS x WIDTH sample history with one write port and one registered read
// port. The storage array has no reset, so it can map onto LUTRAM/BRAM; only
// the read register is reset.
// Ports:
//   clk_in    : clock
//   rst_n_in  : asynchronous active-low reset (read register only)
//   wr_en     : write wr_data to wr_addr on this edge
//   wr_addr   : write address
//   wr_data   : write data
//   rd_en     : load mem[rd_addr] into rd_data; when low rd_data loads zero
//   rd_addr   : read address
//   rd_data   : registered read data
// ---------------------------------------------------------------------------
module sample_ring_buffer #(
    parameter int WIDTH = 8,
    parameter int TAPS  = 32,
    parameter int IDX_W = $clog2(TAPS)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [TAPS];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Loading zero when rd_en is low gives both the zero-fill for words
    // beyond the valid history and the idle value of the output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
// Upstream feeder for the FIR filter. Keeps the last TAPS samples in a ring
// buffer and, for every accepted sample, streams the history newest-first,
// one word per clock: word k is x[n-k].
// Ports:
//   clk_in           : system clock
//   rst_n_in         : asynchronous active-low reset
//   sample_in        : new audio sample
//   sample_valid_in  : sample_in valid this cycle
//   sample_ready_out : a sample can be accepted (IDLE)
//   tap_sample_out   : history word x[n-k] (registered)
//   tap_valid_out    : tap_sample_out valid
//   tap_index_out    : k of the current word, 0 = newest
//   tap_last_out     : high with k = TAPS-1
//   overrun_out      : one-cycle pulse, a sample offered while busy was dropped
// ---------------------------------------------------------------------------
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH,
    parameter int TAPS  = FIR_TAPS,
    parameter int IDX_W = $clog2(TAPS)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid_in,
    output logic             sample_ready_out,
    output logic [WIDTH-1:0] tap_sample_out,
    output logic             tap_valid_out,
    output logic [IDX_W-1:0] tap_index_out,
    output logic             tap_last_out,
    output logic             overrun_out
);

    localparam logic [IDX_W:0]   FILL_MAX = (IDX_W+1)'(TAPS);
    localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(TAPS - 1);

    fir_seq_state_t   state;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] k;
    // One bit wider than the pointers so it can hold the saturated value TAPS.
    logic [IDX_W:0]   fill_cnt;

    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;

    assign sample_ready_out = (state == IDLE);
    assign wr_en            = (state == IDLE) && sample_valid_in;

    // The read register in the ring buffer is the output register for
    // tap_sample_out, so the address for word k is presented during the cycle
    // k is current and the data lands on the same edge that registers
    // tap_index_out <= k. Pointer arithmetic wraps naturally modulo TAPS.
    assign rd_addr = base - k;
    assign rd_en   = (state == STREAM) && ({1'b0, k} < fill_cnt);

    sample_ring_buffer #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .IDX_W (IDX_W)
    ) u_ring (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr),
        .wr_data  (sample_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (tap_sample_out)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            base          <= '0;
            k             <= '0;
            fill_cnt      <= '0;
            tap_valid_out <= 1'b0;
            tap_index_out <= '0;
            tap_last_out  <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            overrun_out <= (state == STREAM) && sample_valid_in;

            case (state)
                IDLE: begin
                    tap_valid_out <= 1'b0;
                    tap_index_out <= '0;
                    tap_last_out  <= 1'b0;
                    if (sample_valid_in) begin
                        base     <= wr_ptr;
                        wr_ptr   <= wr_ptr + 1'b1;
                        fill_cnt <= (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + 1'b1;
                        k        <= '0;
                        state    <= STREAM;
                    end
                end

                STREAM: begin
                    tap_valid_out <= 1'b1;
                    tap_index_out <= k;
                    tap_last_out  <= (k == LAST_K);
                    k             <= k + 1'b1;
                    // Returning to IDLE on the last word lets a new sample be
                    // accepted in the same cycle tap_last_out is visible.
                    if (k == LAST_K) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
// Self-checking bench for fir_tap_sequencer: a table of directed samples with
// hand-computed burst heads, plus hand-written sequences for wrap-around,
// overrun, mid-burst reset and continuous offering of samples.
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;

    localparam int WIDTH = 8;
    localparam int TAPS  = 32;
    localparam int IDX_W = 5;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b1;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid_in = 1'b0;
    logic             sample_ready_out;
    logic [WIDTH-1:0] tap_sample_out;
    logic             tap_valid_out;
    logic [IDX_W-1:0] tap_index_out;
    logic             tap_last_out;
    logic             overrun_out;

    int assertCount = 0;
    int failCount   = 0;

    logic [WIDTH-1:0] expWords [TAPS];

    typedef struct {
        logic [7:0] sample;
        int         gap;
        logic [7:0] k0;
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] k3;
        logic [7:0] k4;
    } vec_t;

    vec_t vecs [5];

    always #5 clk_in = ~clk_in;

    fir_tap_sequencer #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .IDX_W (IDX_W)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .tap_sample_out   (tap_sample_out),
        .tap_valid_out    (tap_valid_out),
        .tap_index_out    (tap_index_out),
        .tap_last_out     (tap_last_out),
        .overrun_out      (overrun_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " valid"},   32'(tap_valid_out),    32'd0);
        checkOutput({tag, " last"},    32'(tap_last_out),     32'd0);
        checkOutput({tag, " index"},   32'(tap_index_out),    32'd0);
        checkOutput({tag, " data"},    32'(tap_sample_out),   32'd0);
        checkOutput({tag, " overrun"}, 32'(overrun_out),      32'd0);
        checkOutput({tag, " ready"},   32'(sample_ready_out), 32'd1);
    endtask

    task automatic doReset();
        sample_valid_in = 1'b0;
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        checkIdleOutputs("in_reset");
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkIdleOutputs("post_reset");
    endtask

    // Called just after a negedge; presents one sample for one cycle and
    // returns at the following negedge (one cycle after the accept edge).
    task automatic applyStimulus(input logic [7:0] value);
        int guard = 0;
        while (!sample_ready_out && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        if (!sample_ready_out) begin
            checkOutput("ready_timeout", 32'(sample_ready_out), 32'd1);
        end
        sample_in       = value;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
    endtask

    task automatic clearExpected();
        for (int k = 0; k < TAPS; k++) expWords[k] = '0;
    endtask

    // Checks a full burst against expWords. injectAt >= 0 offers 0xAA while
    // word injectAt is visible and expects overrun_out on the next word.
    task automatic checkBurst(input string tag, input int injectAt);
        checkOutput({tag, " latency_valid"}, 32'(tap_valid_out),    32'd0);
        checkOutput({tag, " latency_ready"}, 32'(sample_ready_out), 32'd0);
        for (int k = 0; k < TAPS; k++) begin
            @(negedge clk_in);
            checkOutput($sformatf("%s valid k%0d", tag, k), 32'(tap_valid_out), 32'd1);
            checkOutput($sformatf("%s index k%0d", tag, k), 32'(tap_index_out), 32'(k));
            checkOutput($sformatf("%s last k%0d", tag, k), 32'(tap_last_out),
                        32'(k == TAPS-1));
            checkOutput($sformatf("%s ready k%0d", tag, k), 32'(sample_ready_out),
                        32'(k == TAPS-1));
            checkOutput($sformatf("%s overrun k%0d", tag, k), 32'(overrun_out),
                        32'(injectAt >= 0 && k == injectAt + 1));
            checkOutput($sformatf("%s word k%0d", tag, k), 32'(tap_sample_out),
                        32'(expWords[k]));
            if (k == injectAt) begin
                sample_in       = 8'hAA;
                sample_valid_in = 1'b1;
            end else if (k == injectAt + 1) begin
                sample_valid_in = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h05, 1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'h7F, 0, 8'h7F, 8'h05, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h80, 7, 8'h80, 8'h7F, 8'h05, 8'h00, 8'h00};
        vecs[3] = '{8'h00, 0, 8'h00, 8'h80, 8'h7F, 8'h05, 8'h00};
        vecs[4] = '{8'hFF, 3, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h05};

        #1;
        $display("[TB] reset and table-driven bursts");
        doReset();
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < vecs[i].gap; g++) begin
                @(negedge clk_in);
                if (g == 0) checkIdleOutputs($sformatf("gap%0d", i));
            end
            applyStimulus(vecs[i].sample);
            clearExpected();
            expWords[0] = vecs[i].k0;
            expWords[1] = vecs[i].k1;
            expWords[2] = vecs[i].k2;
            expWords[3] = vecs[i].k3;
            expWords[4] = vecs[i].k4;
            checkBurst($sformatf("vec%0d", i), -1);
        end
        @(negedge clk_in);
        checkIdleOutputs("table_end");

        $display("[TB] back-to-back samples 1..33, wrap-around and saturation");
        doReset();
        for (int v = 1; v <= 33; v++) begin
            applyStimulus(8'(v));
            for (int k = 0; k < TAPS; k++) expWords[k] = (k < v) ? 8'(v - k) : 8'h00;
            checkBurst($sformatf("seq%0d", v), -1);
        end
        @(negedge clk_in);
        checkIdleOutputs("seq_end");

        $display("[TB] overrun during burst");
        doReset();
        applyStimulus(8'h11);
        clearExpected();
        expWords[0] = 8'h11;
        checkBurst("ovr", 10);
        @(negedge clk_in);
        checkIdleOutputs("ovr_end");
        applyStimulus(8'h22);
        clearExpected();
        expWords[0] = 8'h22;
        expWords[1] = 8'h11;
        checkBurst("post_ovr", -1);
        @(negedge clk_in);
        checkIdleOutputs("post_ovr_end");

        $display("[TB] reset in the middle of a burst");
        applyStimulus(8'h44);
        repeat (16) @(negedge clk_in);
        checkOutput("midrst pre index", 32'(tap_index_out), 32'd15);
        checkOutput("midrst pre valid", 32'(tap_valid_out), 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkIdleOutputs("midrst async");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        applyStimulus(8'h09);
        clearExpected();
        expWords[0] = 8'h09;
        checkBurst("after_rst", -1);
        @(negedge clk_in);
        checkIdleOutputs("after_rst_end");

        $display("[TB] continuous sample_valid_in");
        for (int d = 0; d < 99; d++) begin
            if (d > 0) @(negedge clk_in);
            checkOutput($sformatf("cont ready d%0d", d), 32'(sample_ready_out),
                        32'(d % 33 == 0));
            checkOutput($sformatf("cont overrun d%0d", d), 32'(overrun_out),
                        32'(d >= 1 && (d - 1) % 33 != 0));
            if (d >= 2 && d % 33 == 2) begin
                checkOutput($sformatf("cont word0 d%0d", d), 32'(tap_sample_out),
                            32'(8'(8'h40 + d - 2)));
                checkOutput($sformatf("cont index0 d%0d", d), 32'(tap_index_out), 32'd0);
            end
            if (d >= 3 && d % 33 == 3) begin
                checkOutput($sformatf("cont word1 d%0d", d), 32'(tap_sample_out),
                            (d == 3) ? 32'h09 : 32'(8'(8'h40 + d - 36)));
            end
            sample_in       = 8'(8'h40 + d);
            sample_valid_in = 1'b1;
        end
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        repeat (40) @(negedge clk_in);
        checkIdleOutputs("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
